vcfg_sequencer: RTL and testbench
=================================

VCFG_SEQUENCER -- requirements
Module: vcfg_sequencer

Interface
REQ-001 Parameter VLEN, default 4096, vector register length in bits; power of two, 128..65536.
REQ-002 Parameter ELEN, default 64, maximum supported SEW in bits; one of 8/16/32/64.
REQ-003 One clock; reset is asynchronous and active-high; ports clk_i and rst_i.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 req_valid_i  input  1  configuration request valid.
REQ-007 req_ready_o  output  1  block can accept a request.
REQ-008 instr_i  input  32  RVV instruction word, decoded with the vsetvli/vsetivli/vsetvl field layouts.
REQ-009 rs1_i  input  64  scalar rs1 value (AVL).
REQ-010 rs2_i  input  64  scalar rs2 value (vtype source for vsetvl).
REQ-011 vec_busy_i  input  1  vector backend has instructions in flight.
REQ-012 resp_valid_o / resp_ready_i  output/input  1/1  response handshake.
REQ-013 resp_result_o  output  64  new vl, zero-extended, for write to rd.
REQ-014 resp_illegal_o  output  1  request was not a configuration instruction.
REQ-015 vtype_o  output  12  current vtype {vill, vlut[2:0], vma, vta, vsew[2:0], vlmul[2:0]}.
REQ-016 vl_o  output  clog2(VLEN)+1  current vl.
REQ-017 cfg_commit_o  output  1  one-cycle pulse when vtype_o/vl_o are written.

Function
REQ-018 Decode: opcode 1010111 and func3 OPCFG required. Bit31=0 -> vsetvli, vtype from zimm11. Bits[31:30]=11 -> vsetivli, vtype from zimm10, AVL=uimm5. Bit31=1 with bits[30:25]=0 -> vsetvl, vtype from rs2_i. Anything else is illegal.
REQ-019 vtype source bit mapping: [2:0] vlmul, [5:3] vsew, [6] vta, [7] vma, [10:8] vlut.
  - vsetivli: vlut[2]=0.
  - vsetvl: rs2_i[63] is ignored.
REQ-020 vill=1 when any of: vlmul=100; SEW>ELEN; vlut in {110,111}; vsetvl with rs2_i[62:11]!=0. On vill: vtype_o=12'h800 and vl=0.
REQ-021 VLMAX = (VLEN>>(3+vsew)) shifted left by vlmul for vlmul 000..011, or shifted right by (8-vlmul) for vlmul 101..111; computed without truncation.
REQ-022 AVL selection:
  - rs1 field!=0: AVL=rs1_i.
  - rs1 field=0 and rd!=0: AVL=all-ones.
  - rs1 field=0 and rd=0: AVL=current vl_o.
  - vl = min(AVL, VLMAX), using full 64-bit compare.
REQ-023 FSM states IDLE, DRAIN, RESP. req_ready_o=1 only in IDLE. At most one request is in flight.
REQ-024 IDLE: on req_valid_i&req_ready_o, capture instr_i/rs1_i/rs2_i. Legal -> DRAIN. Illegal -> RESP with resp_illegal_o=1, resp_result_o=0, CSRs unchanged, no cfg_commit_o.
REQ-025 DRAIN: commit new vtype_o/vl_o at the next edge, pulse cfg_commit_o, go RESP, when either (new vtype == vtype_o) or vec_busy_i=0. Otherwise stay in DRAIN.
REQ-026 RESP: resp_valid_o=1 with stable resp_result_o/resp_illegal_o until resp_ready_i=1; then IDLE. Earliest next accept is the cycle after the response handshake.
REQ-027 Minimum latency (no stall): accept at edge t, commit at edge t+1, resp_valid_o high from t+1 to t+2.
REQ-028 resp_valid_o, cfg_commit_o and req_ready_o are driven from state registers only; no combinational path from resp_ready_i.

Reset
REQ-029 Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, resp_illegal_o=0, resp_result_o=0, cfg_commit_o=0, vtype_o=12'h800, vl_o=0.
REQ-030 Reset asserted in DRAIN or RESP abandons the request: no commit and no response after reset deasserts.

Verification (VLEN=4096, ELEN=64)
REQ-031 vsetvli rd=x5, rs1=x6, rs1_i=100, e32 m1, vec_busy_i=0 -> vl_o=100, vtype_o=12'h010, resp_result_o=100, resp_valid_o one cycle after accept.
REQ-032 vsetivli uimm5=31, e64 m8 -> VLMAX=512, vl_o=31, vtype_o=12'h01B.
REQ-033 vsetvli rs1=x0, rd=x1, e8 m8 -> vl_o=4096; then rs1=x0, rd=x0, e16 m8 -> vl_o=2048 (clamped).
REQ-034 Changed vtype with vec_busy_i high for 5 cycles -> no commit, resp_valid_o low until busy drops, then commit next edge. Same vtype with busy high -> commit with no wait.
REQ-035 vsetvl with rs2_i vlmul=100 -> vtype_o=12'h800, vl_o=0, resp_result_o=0.
REQ-036 Non-config opcode -> resp_illegal_o=1, vtype_o/vl_o unchanged, no cfg_commit_o.
REQ-037 rst_i pulsed while in DRAIN -> no response; outputs at reset values.

Source files
------------

// File: rtl/vcfg_sequencer.sv
// vcfg_sequencer: RVV vsetvli/vsetivli/vsetvl sequencer owning vtype/vl.
// A changed vtype waits for the vector backend to drain; an unchanged vtype commits at once.
module vcfg_sequencer #(
    parameter int VLEN = 4096,
    parameter int ELEN = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            instr_i,
    input  logic [63:0]            rs1_i,
    input  logic [63:0]            rs2_i,
    input  logic                   vec_busy_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [63:0]            resp_result_o,
    output logic                   resp_illegal_o,
    output logic [11:0]            vtype_o,
    output logic [$clog2(VLEN):0]  vl_o,
    output logic                   cfg_commit_o
);
    localparam int VLW = $clog2(VLEN) + 1;
    localparam logic [2:0] MAX_VSEW = 3'($clog2(ELEN) - 3);

    typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_e;

    state_e         state_q;
    logic           req_ready_q, resp_valid_q, resp_illegal_q, cfg_commit_q;
    logic [63:0]    resp_result_q;
    logic [11:0]    vtype_q;
    logic [VLW-1:0] vl_q;
    logic [10:0]    src_q;
    logic           bad_q;
    logic [63:0]    avl_q;

    logic           is_vli, is_ivli, is_vl, legal, bad_d;
    logic [10:0]    src_d;
    logic [63:0]    avl_d;
    logic           vill;
    logic [63:0]    vlmax_base, vlmax;
    logic [11:0]    vtype_d;
    logic [VLW-1:0] vl_d;
    logic           unused_rs2;

    assign unused_rs2 = rs2_i[63];

    // The AVL is resolved at capture; vl_o cannot move while a request is in flight.
    always_comb begin
        is_vli  = ~instr_i[31];
        is_ivli = instr_i[31:30] == 2'b11;
        is_vl   = instr_i[31:25] == 7'b1000000;
        legal   = instr_i[6:0] == 7'b1010111 && instr_i[14:12] == 3'b111 && (is_vli || is_ivli || is_vl);
        src_d   = is_vli ? instr_i[30:20] : is_ivli ? {1'b0, instr_i[29:20]} : rs2_i[10:0];
        bad_d   = is_vl && |rs2_i[62:11];
        avl_d   = is_ivli ? 64'(instr_i[19:15]) : |instr_i[19:15] ? rs1_i :
                  |instr_i[11:7] ? '1 : 64'(vl_q);
    end

    always_comb begin
        vill       = bad_q || src_q[2:0] == 3'b100 || src_q[5:3] > MAX_VSEW || src_q[10:9] == 2'b11;
        vlmax_base = 64'(VLEN) >> ({1'b0, src_q[5:3]} + 4'd3);
        vlmax      = src_q[2] ? vlmax_base >> (4'd8 - {1'b0, src_q[2:0]}) : vlmax_base << src_q[1:0];
        vtype_d    = vill ? 12'h800 : {1'b0, src_q};
        vl_d       = vill ? '0 : avl_q < vlmax ? VLW'(avl_q) : VLW'(vlmax);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_illegal_q <= 1'b0;
            resp_result_q  <= '0;
            cfg_commit_q   <= 1'b0;
            vtype_q        <= 12'h800;
            vl_q           <= '0;
            src_q          <= '0;
            bad_q          <= 1'b0;
            avl_q          <= '0;
        end else begin
            cfg_commit_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid_i && req_ready_q) begin
                    src_q       <= src_d;
                    bad_q       <= bad_d;
                    avl_q       <= avl_d;
                    req_ready_q <= 1'b0;
                    if (legal) begin
                        state_q <= DRAIN;
                    end else begin
                        state_q        <= RESP;
                        resp_valid_q   <= 1'b1;
                        resp_illegal_q <= 1'b1;
                        resp_result_q  <= '0;
                    end
                end
                DRAIN: if (vtype_d == vtype_q || !vec_busy_i) begin
                    vtype_q        <= vtype_d;
                    vl_q           <= vl_d;
                    cfg_commit_q   <= 1'b1;
                    resp_valid_q   <= 1'b1;
                    resp_illegal_q <= 1'b0;
                    resp_result_q  <= 64'(vl_d);
                    state_q        <= RESP;
                end
                RESP: if (resp_ready_i) begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_illegal_o = resp_illegal_q;
    assign resp_result_o  = resp_result_q;
    assign cfg_commit_o   = cfg_commit_q;
    assign vtype_o        = vtype_q;
    assign vl_o           = vl_q;
endmodule

// File: tb/tb_vcfg_sequencer.sv
// tb_vcfg_sequencer: directed and randomized checks of vcfg_sequencer against an arithmetic model.
module tb_vcfg_sequencer;
    localparam int VLEN = 4096;
    localparam int ELEN = 64;
    localparam int VLW = $clog2(VLEN) + 1;

    logic clk = 0, rst = 1;
    logic req_valid = 0, req_ready, vec_busy = 0, resp_valid, resp_ready = 1, resp_illegal, cfg_commit;
    logic [31:0] instr = 0;
    logic [63:0] rs1 = 0, rs2 = 0, resp_result;
    logic [11:0] vtype;
    logic [VLW-1:0] vl;

    int checks = 0, errors = 0;
    logic [11:0] m_vtype = 12'h800;
    logic [63:0] m_vl = 0;

    vcfg_sequencer #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .instr_i(instr), .rs1_i(rs1), .rs2_i(rs2), .vec_busy_i(vec_busy),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_result_o(resp_result),
        .resp_illegal_o(resp_illegal), .vtype_o(vtype), .vl_o(vl), .cfg_commit_o(cfg_commit)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_vli(input logic [4:0] rd, r1, input logic [10:0] z);
        return {1'b0, z, r1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_ivli(input logic [4:0] rd, u, input logic [9:0] z);
        return {2'b11, z, u, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vl(input logic [4:0] rd, r1, r2);
        return {7'b1000000, r2, r1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [10:0] rand_z();
        logic [2:0] lut;
        lut = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
        return {lut, 2'($urandom), 3'($urandom_range(0, 4)), 3'($urandom)};
    endfunction

    // Reference: the configuration rules evaluated with plain integer arithmetic.
    task automatic model(input logic [31:0] ins, input logic [63:0] a, b,
                         output logic legal, output logic [11:0] nvt, output logic [63:0] nvl);
        logic [10:0] z;
        logic vli, ivli, vlk, bad;
        logic [63:0] avl, vlmax;
        int sewb, lm;
        vli  = !ins[31];
        ivli = ins[31:30] == 2'b11;
        vlk  = ins[31] && !ins[30] && ins[29:25] == 0;
        legal = ins[6:0] == 7'h57 && ins[14:12] == 3'd7 && (vli || ivli || vlk);
        z = vli ? ins[30:20] : ivli ? {1'b0, ins[29:20]} : b[10:0];
        sewb = 8 << z[5:3];
        lm = int'(z[2:0]);
        bad = lm == 4 || sewb > ELEN || z[10:8] >= 6 || (vlk && b[62:11] != 0);
        vlmax = lm < 4 ? 64'((VLEN / sewb) * (1 << lm)) : 64'((VLEN / sewb) / (1 << (8 - lm)));
        avl = ivli ? 64'(ins[19:15]) : ins[19:15] != 0 ? a : ins[11:7] != 0 ? '1 : m_vl;
        nvl = bad ? 64'd0 : (avl < vlmax ? avl : vlmax);
        nvt = bad ? 12'h800 : {1'b0, z};
    endtask

    // Issues one request and records what the DUT did; callers compare.
    task automatic send(input logic [31:0] ins, input logic [63:0] a, b, input int busy, hold,
                        output int lat, output logic [63:0] res, output logic ill, output int cm,
                        output logic tmo, stable, rdy_before, rdy_after);
        int k;
        cm = 0; tmo = 0; stable = 1; lat = -1; res = 0; ill = 0; rdy_after = 0;
        instr = ins; rs1 = a; rs2 = b; req_valid = 1; vec_busy = busy > 0; resp_ready = hold == 0;
        rdy_before = req_ready;
        @(posedge clk); #1;
        req_valid = 0; instr = $urandom; rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
        k = 0;
        while (!resp_valid && k < 40) begin
            cm += int'(cfg_commit);
            vec_busy = k + 1 <= busy;
            @(posedge clk); #1;
            k++;
        end
        vec_busy = 0;
        if (!resp_valid) begin
            tmo = 1; resp_ready = 1;
            repeat (50) @(posedge clk);
            #1;
            return;
        end
        cm += int'(cfg_commit);
        lat = k; res = resp_result; ill = resp_illegal;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            cm += int'(cfg_commit);
            if (!resp_valid || resp_result !== res || resp_illegal !== ill) stable = 0;
        end
        resp_ready = 1;
        @(posedge clk); #1;
        cm += int'(cfg_commit);
        rdy_after = req_ready && !resp_valid;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%b exp=0", resp_illegal); end
        checks++; if (resp_result !== 64'd0) begin errors++; $display("FAIL rst_result got=%h exp=0", resp_result); end
        checks++; if (cfg_commit !== 1'b0) begin errors++; $display("FAIL rst_commit got=%b exp=0", cfg_commit); end
        checks++; if (vtype !== 12'h800) begin errors++; $display("FAIL rst_vtype got=%h exp=800", vtype); end
        checks++; if (vl !== '0) begin errors++; $display("FAIL rst_vl got=%0d exp=0", vl); end
    endtask

    task automatic test_directed();
        int lat, cm;
        logic [63:0] res;
        logic ill, tmo, st, rb, ra;
        send(enc_vli(5'd5, 5'd6, 11'h010), 64'd100, 64'd0, 0, 0, lat, res, ill, cm, tmo, st, rb, ra);
        checks++; if (vl !== 13'd100) begin errors++; $display("FAIL e32m1_vl got=%0d exp=100", vl); end
        checks++; if (vtype !== 12'h010) begin errors++; $display("FAIL e32m1_vtype got=%h exp=010", vtype); end
        checks++; if (res !== 64'd100) begin errors++; $display("FAIL e32m1_result got=%0d exp=100", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL e32m1_latency got=%0d exp=1", lat); end
        checks++; if (cm !== 1) begin errors++; $display("FAIL e32m1_commits got=%0d exp=1", cm); end
        send(enc_ivli(5'd1, 5'd31, 10'h01B), 64'd7, 64'd0, 0, 0, lat, res, ill, cm, tmo, st, rb, ra);
        checks++; if (vl !== 13'd31) begin errors++; $display("FAIL ivli_vl got=%0d exp=31", vl); end
        checks++; if (vtype !== 12'h01B) begin errors++; $display("FAIL ivli_vtype got=%h exp=01B", vtype); end
        send(enc_vli(5'd1, 5'd0, 11'h003), 64'd5, 64'd0, 0, 0, lat, res, ill, cm, tmo, st, rb, ra);
        checks++; if (vl !== 13'd4096) begin errors++; $display("FAIL vlmax_e8m8 got=%0d exp=4096", vl); end
        send(enc_vli(5'd0, 5'd0, 11'h00B), 64'd5, 64'd0, 0, 0, lat, res, ill, cm, tmo, st, rb, ra);
        checks++; if (vl !== 13'd2048) begin errors++; $display("FAIL keep_vl_clamp got=%0d exp=2048", vl); end
        checks++; if (res !== 64'd2048) begin errors++; $display("FAIL keep_vl_result got=%0d exp=2048", res); end
        send(32'h00000013, 64'd9, 64'd0, 0, 0, lat, res, ill, cm, tmo, st, rb, ra);
        checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b exp=1", ill); end
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL illegal_result got=%h exp=0", res); end
        checks++; if (cm !== 0) begin errors++; $display("FAIL illegal_commits got=%0d exp=0", cm); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL illegal_latency got=%0d exp=0", lat); end
        checks++; if (vtype !== 12'h00B || vl !== 13'd2048) begin errors++; $display("FAIL illegal_csr got=%h/%0d exp=00B/2048", vtype, vl); end
        send(enc_vl(5'd2, 5'd3, 5'd4), 64'd50, 64'h4, 0, 0, lat, res, ill, cm, tmo, st, rb, ra);
        checks++; if (vtype !== 12'h800) begin errors++; $display("FAIL vill_vtype got=%h exp=800", vtype); end
        checks++; if (vl !== '0 || res !== 64'd0) begin errors++; $display("FAIL vill_vl got=%0d/%0d exp=0/0", vl, res); end
        checks++; if (ill !== 1'b0 || cm !== 1) begin errors++; $display("FAIL vill_commit got=%b/%0d exp=0/1", ill, cm); end
        m_vtype = 12'h800; m_vl = 0;
    endtask

    task automatic test_busy();
        int lat, cm;
        logic [63:0] res;
        logic ill, tmo, st, rb, ra;
        send(enc_vli(5'd5, 5'd6, 11'h010), 64'd100, 64'd0, 0, 0, lat, res, ill, cm, tmo, st, rb, ra);
        send(enc_vli(5'd5, 5'd6, 11'h018), 64'd100, 64'd0, 5, 0, lat, res, ill, cm, tmo, st, rb, ra);
        checks++; if (lat !== 6) begin errors++; $display("FAIL busy_wait_latency got=%0d exp=6", lat); end
        checks++; if (cm !== 1 || vtype !== 12'h018 || vl !== 13'd64) begin errors++; $display("FAIL busy_wait_commit got=%0d/%h/%0d exp=1/018/64", cm, vtype, vl); end
        send(enc_vli(5'd5, 5'd6, 11'h018), 64'd10, 64'd0, 5, 0, lat, res, ill, cm, tmo, st, rb, ra);
        checks++; if (lat !== 1) begin errors++; $display("FAIL busy_same_latency got=%0d exp=1", lat); end
        checks++; if (vl !== 13'd10 || res !== 64'd10) begin errors++; $display("FAIL busy_same_vl got=%0d/%0d exp=10", vl, res); end
        m_vtype = 12'h018; m_vl = 10;
    endtask

    task automatic test_reset_drain();
        instr = enc_vli(5'd1, 5'd2, 11'h008); rs1 = 64'd20; vec_busy = 1; req_valid = 1; resp_ready = 1;
        @(posedge clk); #1;
        req_valid = 0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL drain_state got=%b/%b exp=0/0", resp_valid, req_ready); end
        rst = 1; #2;
        checks++; if (vtype !== 12'h800 || vl !== '0 || req_ready !== 1'b1) begin errors++; $display("FAIL async_rst got=%h/%0d/%b", vtype, vl, req_ready); end
        @(posedge clk); #1;
        rst = 0; vec_busy = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b0 || cfg_commit !== 1'b0) begin errors++; $display("FAIL rst_abandon cyc=%0d got=%b/%b exp=0/0", i, resp_valid, cfg_commit); end
            @(posedge clk); #1;
        end
        checks++; if (vtype !== 12'h800 || vl !== '0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_after got=%h/%0d/%b", vtype, vl, req_ready); end
        m_vtype = 12'h800; m_vl = 0;
    endtask

    task automatic run_random(input int n, input int max_hold);
        int lat, cm, busy, hold, elat;
        logic [63:0] res, a, b, nvl;
        logic [31:0] ins;
        logic [11:0] nvt;
        logic [4:0] rd, r1;
        logic ill, tmo, st, rb, ra, legal;
        for (int i = 0; i < n; i++) begin
            rd = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            r1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            b = {$urandom, $urandom};
            if ($urandom_range(0, 5) != 0) b[62:11] = '0;
            b[10:0] = rand_z();
            a = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 5000));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ins = enc_vli(rd, r1, rand_z());
                4, 5: ins = enc_ivli(rd, r1, rand_z() & 11'h3FF);
                6, 7: ins = enc_vl(rd, r1, 5'($urandom));
                8: ins = $urandom;
                default: ins = enc_vl(rd, r1, 5'($urandom)) ^ (32'h1 << $urandom_range(25, 29)) ^ (($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h0);
            endcase
            busy = $urandom_range(0, 3);
            hold = $urandom_range(0, max_hold);
            model(ins, a, b, legal, nvt, nvl);
            elat = !legal ? 0 : (nvt == m_vtype || busy == 0) ? 1 : busy + 1;
            if (legal) begin m_vtype = nvt; m_vl = nvl; end
            send(ins, a, b, busy, hold, lat, res, ill, cm, tmo, st, rb, ra);
            checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rnd_timeout i=%0d ins=%h", i, ins); end
            checks++; if (rb !== 1'b1 || ra !== 1'b1) begin errors++; $display("FAIL rnd_ready i=%0d got=%b/%b exp=1/1", i, rb, ra); end
            checks++; if (ill !== !legal) begin errors++; $display("FAIL rnd_illegal i=%0d ins=%h got=%b exp=%b", i, ins, ill, !legal); end
            checks++; if (res !== (legal ? nvl : 64'd0)) begin errors++; $display("FAIL rnd_result i=%0d ins=%h got=%0d exp=%0d", i, ins, res, legal ? nvl : 64'd0); end
            checks++; if (vtype !== m_vtype || 64'(vl) !== m_vl) begin errors++; $display("FAIL rnd_csr i=%0d got=%h/%0d exp=%h/%0d", i, vtype, vl, m_vtype, m_vl); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, lat, elat); end
            checks++; if (cm !== int'(legal)) begin errors++; $display("FAIL rnd_commits i=%0d got=%0d exp=%0d", i, cm, int'(legal)); end
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL rnd_stable i=%0d hold=%0d", i, hold); end
        end
    endtask

    task automatic test_random();
        run_random(200, 0);
    endtask

    task automatic test_back_to_back();
        run_random(60, 3);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_directed();
        test_busy();
        test_reset_drain();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
